// File: rtl/dram_pkg.sv
// ---------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the multiplexed-address DRAM bank controller:
//   - dram_state_e : controller state encoding
//   - *_DEF        : default timing / geometry constants
//   - ADDR_BITS    : default CPU address width (2 * ROW_BITS_DEF)
//   - addr_bits()  : CPU address width for an arbitrary row width
// ---------------------------------------------------------------------------
package dram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ROW     = 3'd1,
      ST_COL     = 3'd2,
      ST_PRE     = 3'd3,
      ST_REF     = 3'd4,
      ST_REF_PRE = 3'd5
   } dram_state_e;

   localparam int ROW_BITS_DEF         = 8;
   localparam int DATA_WIDTH_DEF       = 8;
   localparam int T_RCD_DEF            = 1;
   localparam int T_CAS_DEF            = 2;
   localparam int T_RP_DEF             = 2;
   localparam int REFRESH_INTERVAL_DEF = 120;

   localparam int ADDR_BITS = 2 * ROW_BITS_DEF;

   // CPU address carries row and column side by side.
   function automatic int addr_bits(input int row_bits);
      return 2 * row_bits;
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// ---------------------------------------------------------------------------
// dram_refresh_timer
// Free-running refresh interval counter, refresh-pending flag and refresh
// row counter.
//   clk, rst       : clock, synchronous active-high reset
//   clear_i        : refresh completed; clears pending, advances the row
//   refresh_req_o  : refresh wanted (pending, or interval wrapping now)
//   row_o          : row for the next RAS-only refresh
// Macro DRAM_CBR_REFRESH_EN: CAS-before-RAS refresh; the DRAM keeps its own
// row counter, so no row register is built and row_o is tied to zero.
// ---------------------------------------------------------------------------
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int ROW_BITS         = ROW_BITS_DEF,
   parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear_i,
   output logic                refresh_req_o,
   output logic [ROW_BITS-1:0] row_o
);

   localparam int            TW       = $clog2(REFRESH_INTERVAL);
   localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_INTERVAL - 1);

   logic [TW-1:0] tmr_q;
   logic [TW-1:0] tmr_d;
   logic          pending_q;
   logic          pending_d;
   logic          wrap_s;

   // Interval counter wrap and pending flag; a new wrap beats a clear
   always_comb begin
      wrap_s = (tmr_q == TMR_LAST);
      if (wrap_s) begin
         tmr_d = '0;
      end else begin
         tmr_d = tmr_q + TW'(1);
      end
      if (wrap_s) begin
         pending_d = 1'b1;
      end else if (clear_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // Interval counter and pending flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         pending_q <= pending_d;
      end
   end

   // Looking at the wrap itself lets a refresh win over a req sampled on
   // the very edge the interval expires.
   assign refresh_req_o = pending_q | wrap_s;

`ifdef DRAM_CBR_REFRESH_EN
   assign row_o = '0;
`else
   logic [ROW_BITS-1:0] row_q;

   // Refresh row advances modulo 2^ROW_BITS once per finished refresh
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
      end else if (clear_i) begin
         row_q <= row_q + ROW_BITS'(1);
      end else begin
         row_q <= row_q;
      end
   end

   assign row_o = row_q;
`endif

endmodule

// File: rtl/dram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// dram_bank_ctrl
// Controller for a bank of multiplexed-address DRAMs. Turns a synchronous
// req/ack CPU port into row/column address mux, nras, ncas and nwe with
// cycle-counted timing, and inserts periodic refresh cycles.
//   clk, rst         : clock, synchronous active-high reset
//   req_i/we_i       : access request (held until ack_o), 1 = write
//   addr_i           : {col, row}; row in the low ROW_BITS bits
//   wdata_i          : write data, valid with req_i
//   rdata_o          : read data, valid with ack_o on a read
//   ack_o            : one-cycle completion pulse
//   busy_o           : controller not idle
//   l_o              : multiplexed DRAM address
//   nras_o/ncas_o/nwe_o : DRAM strobes, active low
//   dq_out_o/dq_oe_o : data and tri-state enable toward the DRAM
//   dq_in_i          : data from the DRAM
// All outputs are registered.
// Macro DRAM_CBR_REFRESH_EN: CAS-before-RAS refresh instead of RAS-only.
// ---------------------------------------------------------------------------
module dram_bank_ctrl
   import dram_pkg::*;
#(
   parameter int ROW_BITS         = ROW_BITS_DEF,
   parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
   parameter int T_RCD            = T_RCD_DEF,
   parameter int T_CAS            = T_CAS_DEF,
   parameter int T_RP             = T_RP_DEF,
   parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_i,
   input  logic                            we_i,
   input  logic [addr_bits(ROW_BITS)-1:0]  addr_i,
   input  logic [DATA_WIDTH-1:0]           wdata_i,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic                            ack_o,
   output logic                            busy_o,
   output logic [ROW_BITS-1:0]             l_o,
   output logic                            nras_o,
   output logic                            ncas_o,
   output logic                            nwe_o,
   output logic [DATA_WIDTH-1:0]           dq_out_o,
   output logic                            dq_oe_o,
   input  logic [DATA_WIDTH-1:0]           dq_in_i
);

   localparam int AW = addr_bits(ROW_BITS);
   localparam int CW = $clog2(T_RCD + T_CAS + T_RP + 1);

`ifdef DRAM_CBR_REFRESH_EN
   // One extra leading cycle with only ncas low.
   localparam int REF_CYC = T_RCD + T_CAS + 1;
`else
   localparam int REF_CYC = T_RCD + T_CAS;
`endif

   // Counter load values are "cycles in state minus one".
   localparam logic [CW-1:0] D_ROW = CW'(T_RCD - 1);
   localparam logic [CW-1:0] D_COL = CW'(T_CAS - 1);
   localparam logic [CW-1:0] D_PRE = CW'(T_RP - 1);
   localparam logic [CW-1:0] D_REF = CW'(REF_CYC - 1);

   dram_state_e           state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [ROW_BITS-1:0]   l_q, l_d;
   logic                  nras_q, nras_d;
   logic                  ncas_q, ncas_d;
   logic                  nwe_q, nwe_d;
   logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
   logic                  dq_oe_q, dq_oe_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ack_q, ack_d;
   logic                  busy_q, busy_d;
   logic                  refresh_req_s;
   logic                  ref_clear_s;
   logic [ROW_BITS-1:0]   ref_row_s;

   dram_refresh_timer #(
      .ROW_BITS         (ROW_BITS),
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (ref_clear_s),
      .refresh_req_o (refresh_req_s),
      .row_o         (ref_row_s)
   );

   // Next state plus next values of every registered output
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      ack_d       = 1'b0;
      ref_clear_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (refresh_req_s) begin
               state_d = ST_REF;
               cnt_d   = D_REF;
            end else if (req_i) begin
               state_d = ST_ROW;
               cnt_d   = D_ROW;
               addr_d  = addr_i;
               we_d    = we_i;
               wdata_d = wdata_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ROW: begin
            if (cnt_q == '0) begin
               state_d = ST_COL;
               cnt_d   = D_COL;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_COL: begin
            if (cnt_q == '0) begin
               // Data has had the whole CAS window to settle.
               if (!we_q) begin
                  rdata_d = dq_in_i;
               end else begin
                  rdata_d = rdata_q;
               end
               ack_d   = 1'b1;
               state_d = ST_PRE;
               cnt_d   = D_PRE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_PRE: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_REF: begin
            if (cnt_q == '0) begin
               state_d = ST_REF_PRE;
               cnt_d   = D_PRE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_REF_PRE: begin
            if (cnt_q == '0) begin
               ref_clear_s = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Pins follow the state being entered so they line up with it.
      nras_d   = 1'b1;
      ncas_d   = 1'b1;
      nwe_d    = 1'b1;
      dq_oe_d  = 1'b0;
      l_d      = l_q;
      dq_out_d = dq_out_q;
      busy_d   = (state_d != ST_IDLE);

      case (state_d)
         ST_ROW, ST_COL: begin
            if (state_d == ST_ROW) begin
               l_d = addr_d[ROW_BITS-1:0];
            end else begin
               l_d    = addr_d[AW-1:ROW_BITS];
               ncas_d = 1'b0;
            end
            nras_d = 1'b0;
            // Early write: nwe and data are set up before ncas falls.
            if (we_d) begin
               nwe_d    = 1'b0;
               dq_oe_d  = 1'b1;
               dq_out_d = wdata_d;
            end else begin
               nwe_d    = 1'b1;
               dq_oe_d  = 1'b0;
            end
         end
         ST_REF: begin
            l_d = ref_row_s;
`ifdef DRAM_CBR_REFRESH_EN
            // ncas leads nras by one cycle and stays low while nras is low.
            ncas_d = 1'b0;
            if (cnt_d == D_REF) begin
               nras_d = 1'b1;
            end else begin
               nras_d = 1'b0;
            end
`else
            nras_d = 1'b0;
`endif
         end
         default: begin
            l_d = l_q;
         end
      endcase
   end

   // State, latched request and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         l_q      <= '0;
         nras_q   <= 1'b1;
         ncas_q   <= 1'b1;
         nwe_q    <= 1'b1;
         dq_out_q <= '0;
         dq_oe_q  <= 1'b0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         l_q      <= l_d;
         nras_q   <= nras_d;
         ncas_q   <= ncas_d;
         nwe_q    <= nwe_d;
         dq_out_q <= dq_out_d;
         dq_oe_q  <= dq_oe_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign ack_o    = ack_q;
   assign busy_o   = busy_q;
   assign l_o      = l_q;
   assign nras_o   = nras_q;
   assign ncas_o   = ncas_q;
   assign nwe_o    = nwe_q;
   assign dq_out_o = dq_out_q;
   assign dq_oe_o  = dq_oe_q;

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dram_bank_ctrl
// Bench for dram_bank_ctrl: a DRAM bank model reacting to the strobes, a
// reference memory behind a scoreboard queue, and a monitor popping and
// comparing on every ack. Refresh rows and spacing are checked from the
// strobe activity seen by the bank model.
// ---------------------------------------------------------------------------
module tb_dram_bank_ctrl;
   import dram_pkg::*;

   localparam int RB = ROW_BITS_DEF;
   localparam int DW = DATA_WIDTH_DEF;
`ifdef DRAM_CBR_REFRESH_EN
   localparam int COLL_LAT = 10;
   localparam int RAND_MAX = 13;
`else
   localparam int COLL_LAT = 9;
   localparam int RAND_MAX = 12;
`endif

   typedef struct {
      bit            is_rd;
      logic [DW-1:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 req_i = 1'b0;
   logic                 we_i = 1'b0;
   logic [ADDR_BITS-1:0] addr_i = '0;
   logic [DW-1:0]        wdata_i = '0;
   logic [DW-1:0]        rdata_o;
   logic                 ack_o;
   logic                 busy_o;
   logic [RB-1:0]        l_o;
   logic                 nras_o;
   logic                 ncas_o;
   logic                 nwe_o;
   logic [DW-1:0]        dq_out_o;
   logic                 dq_oe_o;
   logic [DW-1:0]        dq_in_i = 8'hEE;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   bit [DW-1:0] ref_mem [0:(1<<ADDR_BITS)-1];
   bit [DW-1:0] bank    [0:(1<<ADDR_BITS)-1];
   logic [RB-1:0] rec_l [0:63];
   logic [4:0]    rec_st[0:63];
   logic [DW-1:0] rec_d [0:63];
   int   ref_cnt = 0;
   bit   idle_phase = 1'b0;

   dram_bank_ctrl #(
      .ROW_BITS(RB), .DATA_WIDTH(DW), .T_RCD(1), .T_CAS(2), .T_RP(2),
      .REFRESH_INTERVAL(120)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o),
      .l_o(l_o), .nras_o(nras_o), .ncas_o(ncas_o), .nwe_o(nwe_o),
      .dq_out_o(dq_out_o), .dq_oe_o(dq_oe_o), .dq_in_i(dq_in_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Cycles since reset release; cyc == k right after the k-th edge.
   initial forever begin
      @(posedge clk);
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
   end

   // Scoreboard monitor: every ack must match the oldest expectation.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && ack_o) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack actual_queue=0 required_queue>=1");
         end else begin
            e = sb_q.pop_front();
            if (e.is_rd) check("read_data", rdata_o, e.data);
         end
      end
   end

   // DRAM bank model: latch row/col on strobe falls, early write on ncas
   // fall, read data presented while ras/cas are low; spots refreshes.
   initial begin
      bit p_nras, p_ncas, cas_in_ras, cbr_follow, prev_ref_idle;
      logic [RB-1:0] b_row, b_col;
      int fall_cyc, prev_fall_cyc;
      p_nras = 1'b1; p_ncas = 1'b1; cas_in_ras = 1'b0; cbr_follow = 1'b0;
      prev_ref_idle = 1'b0; b_row = '0; b_col = '0; fall_cyc = 0; prev_fall_cyc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_nras = 1'b1; p_ncas = 1'b1; cas_in_ras = 1'b0; cbr_follow = 1'b0;
            dq_in_i = 8'hEE;
         end else begin
            if (cbr_follow) begin
               check("cbr_nras_follows", nras_o, 1'b0);
               cbr_follow = 1'b0;
            end
            if (p_nras && !nras_o) begin
               b_row = l_o;
               cas_in_ras = !ncas_o;
               fall_cyc = cyc;
            end
            if (p_ncas && !ncas_o) begin
               if (!nras_o) begin
                  b_col = l_o;
                  cas_in_ras = 1'b1;
                  if (!nwe_o) begin
                     check("write_dq_oe", dq_oe_o, 1'b1);
                     bank[{b_col, b_row}] = dq_out_o;
                  end
               end else begin
`ifdef DRAM_CBR_REFRESH_EN
                  check("cbr_l_zero", l_o, '0);
                  cbr_follow = 1'b1;
                  if (idle_phase && prev_ref_idle) check("ref_interval", cyc - prev_fall_cyc, 120);
                  prev_ref_idle = idle_phase;
                  prev_fall_cyc = cyc;
                  ref_cnt++;
`else
                  check("ncas_fall_needs_ras", nras_o, 1'b0);
`endif
               end
            end
            if (!nras_o && !ncas_o && nwe_o) dq_in_i = bank[{b_col, b_row}];
            else                             dq_in_i = 8'hEE;
`ifndef DRAM_CBR_REFRESH_EN
            if (!p_nras && nras_o && !cas_in_ras) begin
               check("ref_row", b_row, ref_cnt % 256);
               if (idle_phase && prev_ref_idle) check("ref_interval", fall_cyc - prev_fall_cyc, 120);
               prev_ref_idle = idle_phase;
               prev_fall_cyc = fall_cyc;
               ref_cnt++;
            end
`endif
            p_nras = nras_o;
            p_ncas = ncas_o;
         end
      end
   end

   // Issue one access at the current negedge; latency counts negedges
   // until ack, so an uncontended access answers at 1+T_RCD+T_CAS = 4.
   task automatic do_access(input bit wr, input logic [ADDR_BITS-1:0] a,
                            input logic [DW-1:0] d, input int lo, input int hi,
                            input string nm);
      exp_t e;
      int   lat;
      bit   got;
      req_i = 1'b1; we_i = wr; addr_i = a; wdata_i = d;
      e.is_rd = !wr;
      if (wr) begin
         ref_mem[a] = d;
         e.data = '0;
      end else begin
         e.data = ref_mem[a];
      end
      sb_q.push_back(e);
      lat = 0; got = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         rec_l[lat] = l_o; rec_d[lat] = dq_out_o;
         rec_st[lat] = {nras_o, ncas_o, nwe_o, dq_oe_o, busy_o};
         if (ack_o) got = 1'b1;
      end
      req_i = 1'b0;
      check({nm, "_ack_seen"}, got, 1'b1);
      checks++;
      if (lat < lo || lat > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", nm, lat, lo, hi);
      end
   endtask

   initial begin
      int n, gap;
      bit wr;
      logic [ADDR_BITS-1:0] a;
      logic [DW-1:0] d;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_strobes", {nras_o, ncas_o, nwe_o}, 3'b111);
      check("rst_l", l_o, '0);
      check("rst_oe_ack_busy", {dq_oe_o, ack_o, busy_o}, 3'b000);
      check("rst_data", {dq_out_o, rdata_o}, 16'h0000);

      // Reset in the middle of a read's COL phase: strobes drop, no ack
      rst = 1'b0;
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0102;
      n = 0;
      while (ncas_o && n < 20) begin @(negedge clk); n++; end
      check("abort_reached_col", ncas_o, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_strobes", {nras_o, ncas_o, nwe_o}, 3'b111);
      check("rst_mid_ack_busy", {ack_o, busy_o}, 2'b00);
      repeat (2) @(negedge clk);
      req_i = 1'b0;
      rst = 1'b0;

      // Directed early write with pin-level checks
      repeat (2) @(negedge clk);
      do_access(1'b1, 16'h12A5, 8'h3C, 4, 4, "wr_lat");
      check("wr_row_l", rec_l[1], 8'hA5);
      check("wr_row_pins", rec_st[1], 5'b01011);
      check("wr_row_dq", rec_d[1], 8'h3C);
      for (int i = 2; i <= 3; i++) begin
         check("wr_col_l", rec_l[i], 8'h12);
         check("wr_col_pins", rec_st[i], 5'b00011);
      end
      check("wr_pre_pins", rec_st[4], 5'b11101);

      // Read back through the bank model
      repeat (4) @(negedge clk);
      do_access(1'b0, 16'h12A5, 8'h00, 4, 4, "rd_lat");
      check("rd_row_pins", rec_st[1], 5'b01101);

      // Request raised the cycle pending sets: refresh first, then access
      while (cyc < 120) @(negedge clk);
      do_access(1'b0, 16'h12A5, 8'h00, COLL_LAT, COLL_LAT, "collision_lat");
      check("collision_ref_done", ref_cnt, 1);

      // Randomised traffic over a small address pool
      for (int i = 0; i < 300; i++) begin
         gap = $urandom_range(0, 4);
         repeat (gap) @(negedge clk);
         wr = 1'($urandom_range(0, 1));
         a  = ADDR_BITS'($urandom) & 16'h0707;
         d  = DW'($urandom);
         do_access(wr, a, d, 4, RAND_MAX, "rand_lat");
      end

      // Idle until the refresh row has wrapped past 255
      repeat (20) @(negedge clk);
      idle_phase = 1'b1;
      n = 0;
      while (ref_cnt < 258 && n < 40000) begin @(negedge clk); n++; end
      check("ref_count_reached", (ref_cnt >= 258), 1'b1);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog time_limit_expired");
      $fatal(1, "watchdog");
   end

endmodule
